// File: rtl/color_mask_pkg.sv
// Shared types and defaults for the colour-key mask stream: FSM states, default geometry,
// and the default key-colour bounds (channel 0 in the least significant byte).
package color_mask_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_LENGTH   = 32;
  localparam int DEF_CHANNELS = 3;
  localparam int DEF_PIX_W    = 8;

  // Former green-key constants, packed {ch2, ch1, ch0}
  localparam logic [DEF_CHANNELS*DEF_PIX_W-1:0] DEF_LOWER = {8'd0,  8'd100, 8'd0};
  localparam logic [DEF_CHANNELS*DEF_PIX_W-1:0] DEF_UPPER = {8'd90, 8'd255, 8'd90};

endpackage

// File: rtl/color_in_range.sv
// Combinational inclusive per-channel bound compare; zero latency, no flow control.
// background=1 only when every channel lies within [lower, upper] (unsigned).
module color_in_range #(
  parameter int CHANNELS = 3,
  parameter int PIX_W    = 8
) (
  input  logic [CHANNELS*PIX_W-1:0] pix,
  input  logic [CHANNELS*PIX_W-1:0] lower,
  input  logic [CHANNELS*PIX_W-1:0] upper,
  output logic                      background
);

  always_comb begin
    background = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      if ((pix[c*PIX_W +: PIX_W] < lower[c*PIX_W +: PIX_W]) ||
          (pix[c*PIX_W +: PIX_W] > upper[c*PIX_W +: PIX_W]))
        background = 1'b0;
    end
  end

endmodule

// File: rtl/color_mask_stream.sv
// Raster pixel stream -> registered foreground mask + per-frame count/bbox (COLOR_MASK_BBOX_EN).
// One-cycle mask latency; input stalls while the output register is held by m_ready=0.
module color_mask_stream
  import color_mask_pkg::*;
#(
  parameter int  WIDTH    = DEF_WIDTH,
  parameter int  LENGTH   = DEF_LENGTH,
  parameter int  CHANNELS = DEF_CHANNELS,
  parameter int  PIX_W    = DEF_PIX_W,
  localparam int DW       = CHANNELS * PIX_W,
  localparam int RW       = $clog2(LENGTH),
  localparam int CW       = $clog2(WIDTH),
  localparam int FW       = $clog2(WIDTH * LENGTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] lower,
  input  logic [DW-1:0] upper,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_mask,
  output logic [RW-1:0] m_row,
  output logic [CW-1:0] m_col,
  output logic          m_last,
  output logic          busy,
  output logic          stats_valid,
  output logic [FW-1:0] fg_count,
  output logic          bbox_valid,
  output logic [RW-1:0] bbox_rmin,
  output logic [RW-1:0] bbox_rmax,
  output logic [CW-1:0] bbox_cmin,
  output logic [CW-1:0] bbox_cmax
);

  localparam logic [RW-1:0] ROW_LAST = RW'(LENGTH - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);

  state_t        state, state_nxt;
  logic [DW-1:0] lo_q, hi_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          background, fg, out_free, accept, last_pix, frame_start;

  color_in_range #(.CHANNELS(CHANNELS), .PIX_W(PIX_W)) u_range (
    .pix        (s_data),
    .lower      (lo_q),
    .upper      (hi_q),
    .background (background)
  );

  assign fg          = !background;
  assign out_free    = !m_valid || m_ready;
  assign accept      = s_valid && s_ready;
  assign last_pix    = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign frame_start = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    s_ready     = 1'b0;
    busy        = 1'b1;
    stats_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        s_ready = out_free;
        if (accept && last_pix) state_nxt = DRAIN;
      end
      DRAIN:  if (out_free) state_nxt = REPORT;
      REPORT: begin
        stats_valid = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q     <= '0;
      hi_q     <= '0;
      row_q    <= '0;
      col_q    <= '0;
      fg_count <= '0;
      m_valid  <= 1'b0;
      m_mask   <= 1'b0;
      m_row    <= '0;
      m_col    <= '0;
      m_last   <= 1'b0;
    end else begin
      if (frame_start) begin
        lo_q     <= lower;
        hi_q     <= upper;
        row_q    <= '0;
        col_q    <= '0;
        fg_count <= '0;
      end
      // The output register refills on the same edge it drains
      if (accept) begin
        m_valid <= 1'b1;
        m_mask  <= fg;
        m_row   <= row_q;
        m_col   <= col_q;
        m_last  <= last_pix;
        if (fg) fg_count <= fg_count + FW'(1);
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= last_pix ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef COLOR_MASK_BBOX_EN
  logic [RW-1:0] rmin_q, rmax_q;
  logic [CW-1:0] cmin_q, cmax_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rmin_q <= '0;
      rmax_q <= '0;
      cmin_q <= '0;
      cmax_q <= '0;
    end else if (frame_start) begin
      rmin_q <= '0;
      rmax_q <= '0;
      cmin_q <= '0;
      cmax_q <= '0;
    end else if (accept && fg) begin
      // First foreground pixel of the frame seeds all four edges
      if (fg_count == '0) begin
        rmin_q <= row_q;
        rmax_q <= row_q;
        cmin_q <= col_q;
        cmax_q <= col_q;
      end else begin
        if (row_q < rmin_q) rmin_q <= row_q;
        if (row_q > rmax_q) rmax_q <= row_q;
        if (col_q < cmin_q) cmin_q <= col_q;
        if (col_q > cmax_q) cmax_q <= col_q;
      end
    end
  end

  assign bbox_valid = (fg_count != '0);
  assign bbox_rmin  = rmin_q;
  assign bbox_rmax  = rmax_q;
  assign bbox_cmin  = cmin_q;
  assign bbox_cmax  = cmax_q;
`else
  assign bbox_valid = 1'b0;
  assign bbox_rmin  = '0;
  assign bbox_rmax  = '0;
  assign bbox_cmin  = '0;
  assign bbox_cmax  = '0;
`endif

endmodule
